// File: rtl/instability_pkg.sv
// Shared types and helpers for the instability sweeper.
package instability_pkg;

  typedef enum logic {SWEEP, LOCKED} inst_state_t;

  localparam int FN_W = 32;

  // Saturating subtract: floors at zero instead of wrapping.
  function automatic logic [FN_W-1:0] clamp_sub(input logic [FN_W-1:0] a,
                                                input logic [FN_W-1:0] b);
    return (a >= b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/instability_peak_tracker.sv
// Running-peak tracker: holds the best Q seen and the i_ref that produced it,
// and flags a drop of more than DELTA below that peak.
module instability_peak_tracker #(
  parameter int WIDTH = 10,
  parameter int DELTA = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] i_ref,
  output logic [WIDTH-1:0] peak_q,
  output logic [WIDTH-1:0] peak_i,
  output logic             new_peak,
  output logic             drop_gt_delta
);

  logic [WIDTH:0] drop;

  // Strict compare keeps the earliest i_ref on equal Q.
  assign new_peak      = q > peak_q;
  assign drop          = {1'b0, peak_q} - {1'b0, q};
  assign drop_gt_delta = !new_peak && (drop > (WIDTH+1)'(DELTA));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
      peak_i <= '0;
    end else if (sample && new_peak) begin
      peak_q <= q;
      peak_i <= i_ref;
    end
  end

endmodule

// File: rtl/instability_detect.sv
// Closed-loop i_ref sweeper: ramps i_ref_setup, locks on Q instability or range end.
// Define INSTABILITY_STATUS_EN to add registered locked/unstable status outputs.
module instability_detect
  import instability_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DELTA      = 50,
  parameter int IREF_DELTA = 10,
  parameter int SETTLE     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_measured,
`ifdef INSTABILITY_STATUS_EN
  output logic             locked,
  output logic             unstable,
`endif
  output logic [WIDTH-1:0] i_ref_setup
);

  localparam int                DW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [DW-1:0]     LAST  = DW'(SETTLE - 1);
  localparam logic [WIDTH-1:0]  I_MAX = '1;

  inst_state_t      state;
  logic [DW-1:0]    dwell;
  logic             sample;
  logic [WIDTH-1:0] peak_q, peak_i;
  logic             new_peak, drop_gt_delta;

  // Q is only trusted on the final cycle of each dwell.
  assign sample = (state == SWEEP) && (dwell == LAST);

  instability_peak_tracker #(.WIDTH(WIDTH), .DELTA(DELTA)) u_peak (
    .clk           (clk),
    .rst           (rst),
    .sample        (sample),
    .q             (q_measured),
    .i_ref         (i_ref_setup),
    .peak_q        (peak_q),
    .peak_i        (peak_i),
    .new_peak      (new_peak),
    .drop_gt_delta (drop_gt_delta)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SWEEP;
      dwell       <= '0;
      i_ref_setup <= '0;
`ifdef INSTABILITY_STATUS_EN
      locked      <= 1'b0;
      unstable    <= 1'b0;
`endif
    end else if (state == SWEEP) begin
      if (sample) begin
        dwell <= '0;
        if (drop_gt_delta) begin
          i_ref_setup <= WIDTH'(clamp_sub(FN_W'(peak_i), FN_W'(IREF_DELTA)));
          state       <= LOCKED;
`ifdef INSTABILITY_STATUS_EN
          locked      <= 1'b1;
          unstable    <= 1'b1;
`endif
        end else if (i_ref_setup != I_MAX) begin
          i_ref_setup <= i_ref_setup + 1'b1;
        end else begin
          // Range exhausted: park on the peak, including one found on this very sample.
          i_ref_setup <= new_peak ? i_ref_setup : peak_i;
          state       <= LOCKED;
`ifdef INSTABILITY_STATUS_EN
          locked      <= 1'b1;
`endif
        end
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instability_detect.sv
// Randomized + directed bench for instability_detect against a table-walk reference model.
module tb_instability_detect;

  localparam int WIDTH = 10, DELTA = 50, IREF_DELTA = 10, SETTLE = 2;
  localparam int N = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] q_measured;
  logic [WIDTH-1:0] i_ref_setup;
`ifdef INSTABILITY_STATUS_EN
  logic             locked, unstable;
`endif

  int qt [N];
  bit q_zero = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Plant model: Q is a lookup on the currently applied i_ref.
  always_comb begin
    q_measured = '0;
    if (!q_zero) q_measured = WIDTH'(qt[i_ref_setup]);
  end

  instability_detect #(.WIDTH(WIDTH), .DELTA(DELTA), .IREF_DELTA(IREF_DELTA), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .q_measured  (q_measured),
`ifdef INSTABILITY_STATUS_EN
    .locked      (locked),
    .unstable    (unstable),
`endif
    .i_ref_setup (i_ref_setup)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Walk the Q table the way the sweep visits it; report lock step, final i_ref, cause.
  task automatic model(output int lock_i, output int fin, output bit unst);
    int pq, pi;
    pq = 0; pi = 0;
    for (int i = 0; i < N; i++) begin
      if (qt[i] > pq) begin
        pq = qt[i]; pi = i;
      end else if (pq - qt[i] > DELTA) begin
        lock_i = i; unst = 1'b1;
        fin = (pi >= IREF_DELTA) ? pi - IREF_DELTA : 0;
        return;
      end
    end
    lock_i = N - 1; fin = pi; unst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_iref", i_ref_setup, 0);
    rst = 1'b0;
  endtask

  // Called at the negedge right after reset release; checks every cycle until locked+extra.
  task automatic run(input string tag, input int extra);
    int lock_i, fin, lock_cyc, exp;
    bit unst;
    model(lock_i, fin, unst);
    lock_cyc = (lock_i + 1) * SETTLE;
    for (int k = 0; k <= lock_cyc + extra; k++) begin
      exp = (k < lock_cyc) ? k / SETTLE : fin;
      chk(tag, i_ref_setup, exp);
      @(negedge clk);
    end
`ifdef INSTABILITY_STATUS_EN
    chk({tag, "_locked"}, locked, 1);
    chk({tag, "_unstable"}, unstable, unst);
`endif
  endtask

  initial begin
    // Rising then drop: lock at step 601, parked at 590.
    for (int i = 0; i < N; i++) qt[i] = (i <= 600) ? i : 400;
    do_reset();
`ifdef INSTABILITY_STATUS_EN
    chk("reset_locked", locked, 0);
    chk("reset_unstable", unstable, 0);
`endif
    run("rise_drop", 4);
    chk("rise_drop_final", i_ref_setup, 590);

    // Locked must ignore Q entirely.
    q_zero = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("locked_hold", i_ref_setup, 590);
    end
    q_zero = 1'b0;

    // Drop of exactly DELTA is tolerated; sweep runs to the end and parks on the peak.
    for (int i = 0; i < N; i++) qt[i] = (i <= 600) ? i : 550;
    do_reset();
    run("exact_delta", 4);
    chk("exact_delta_final", i_ref_setup, 600);

    // Early peak: back-off must clamp at zero.
    for (int i = 0; i < N; i++) qt[i] = (i <= 5) ? i * 100 : 0;
    do_reset();
    run("clamp", 4);
    chk("clamp_final", i_ref_setup, 0);

    // Monotonic Q: full range sweep ending at max.
    for (int i = 0; i < N; i++) qt[i] = i;
    do_reset();
    run("mono", 10);
    chk("mono_final", i_ref_setup, N - 1);

    // Reset mid-sweep at i_ref=300, then confirm the old peak (300) no longer matters.
    do_reset();
    for (int k = 0; k < 300 * SETTLE; k++) @(negedge clk);
    chk("pre_rst_iref", i_ref_setup, 300);
    rst = 1'b1;
    #1;
    chk("async_rst_iref", i_ref_setup, 0);
    for (int i = 0; i < N; i++) qt[i] = 100;
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 4);
    chk("post_rst_final", i_ref_setup, 0);

    // Randomized: rising to a random peak, then random values at or below it.
    for (int t = 0; t < 4; t++) begin
      int p;
      p = $urandom_range(20, 900);
      for (int i = 0; i < N; i++) qt[i] = (i <= p) ? i : $urandom_range(0, p);
      do_reset();
      run("rand_peak", 6);
    end

    // Randomized: fully random Q.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) qt[i] = $urandom_range(0, N - 1);
      do_reset();
      run("rand_full", 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
